seq_control: RTL and testbench
==============================

Name: seq_control

Overview:
- Next-generation instruction sequencer for the cellular-automaton processor core.
- Produces the fetch PC and tracks a parametrised call stack, with overflow/underflow fault detection.
- Adds a single-level hardware loop (LOOP/ENDL), a HALT/resume state, and fetch-valid / execute-stall handshakes.
- Sits between instruction memory and the cell array; consumes `diverge_consensus` from the array.

Parameters:
- PC_WIDTH, 12, program-counter width in bits; must be >= 12.
- STACK_DEPTH, 16, number of call-stack entries; must be >= 2.
- INSTR_WIDTH, 16, instruction width in bits; PC step = INSTR_WIDTH/8.
- LOOP_CNT_WIDTH, 8, width of the loop iteration counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- instruction  in  INSTR_WIDTH  current instruction. Fields: opcode[15:12], addr[11:0], imm[7:0].
- instr_valid  in  1  instruction corresponds to program_counter.
- stall  in  1  execute stage cannot accept; hold the PC.
- diverge_consensus  in  1  all cells agree on the UNL branch.
- resume  in  1  leave HALTED.
- fault_clr  in  1  leave FAULT.
- program_counter  out  PC_WIDTH  registered fetch address.
- next_program_counter  out  PC_WIDTH  combinational PC for the next cycle.
- stack_depth  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- advance  out  1  instruction retires this cycle (comb).
- halted  out  1  state == HALTED.
- fault  out  1  state == FAULT.
- fault_code  out  2  00 none, 01 overflow, 10 underflow, 11 ENDL without active loop.

Behaviour:
- Reset (async, rst_n low):
  - program_counter = 0, stack_depth = 0, loop inactive, loop counter = 0, state = RUN.
  - halted = 0, fault = 0, fault_code = 0.
- States: RUN, HALTED, FAULT.
- `advance` = (state == RUN) && instr_valid && !stall.
  - When `advance` is 0, next_program_counter = program_counter and no other state changes.
- Decode when `advance` is 1 (step = INSTR_WIDTH/8; addresses zero-extended to PC_WIDTH; arithmetic wraps modulo 2^PC_WIDTH):
  - JUMP: PC <= addr.
  - UNL: PC <= diverge_consensus ? imm : PC+step.
  - CALL, depth < STACK_DEPTH: stack[depth] <= PC+step; depth++; PC <= addr.
  - CALL, depth == STACK_DEPTH: no push; PC held; state -> FAULT; fault_code = 01.
  - RET, depth > 0: PC <= stack[depth-1]; depth--.
  - RET, depth == 0: PC held; state -> FAULT; fault_code = 10.
  - LOOP: loop_start <= PC+step; count <= (imm == 0) ? 1 : imm; loop active; PC <= PC+step.
    - A LOOP while a loop is already active overwrites it (single level).
  - ENDL, active and count > 1: count--; PC <= loop_start.
  - ENDL, active and count == 1: loop inactive; PC <= PC+step.
  - ENDL, inactive: PC held; FAULT; fault_code = 11.
  - HALT: PC <= PC+step; state -> HALTED.
  - Any other opcode: PC <= PC+step.
- HALTED:
  - resume = 1 -> RUN on the next edge; PC is unchanged (already at PC+step).
  - `stall` and `instr_valid` are ignored in this state.
- FAULT:
  - Sticky; PC frozen.
  - fault_clr = 1 -> RUN, PC = 0, depth = 0, loop inactive, fault_code = 0.
  - A resume input in FAULT is ignored.
- A stack entry is written only on a successful CALL. Stack contents are not cleared by reset; only depth is.
- Latency: a control-flow target appears on program_counter one cycle after the advancing edge. next_program_counter shows it in the same cycle.
- Simultaneous stall and instr_valid: the stall wins; the instruction is re-presented later.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined:
  - Adds outputs retired_count (32) and stall_count (32), both reset to 0.
  - retired_count increments on every `advance` cycle.
  - stall_count increments on every RUN cycle with instr_valid && stall.
  - Both counters saturate at 2^32-1.
- When undefined: these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package seq_pkg holds:
  - state enum {RUN, HALTED, FAULT}.
  - fault_code enum.
  - Opcode constants; LOOP, ENDL and HALT are added next to the existing JUMP/UNL/CALL/RET encodings.
  - Field-slice localparams for opcode/addr/imm.
- Natural sub-module: seq_call_stack.
  - Parametrised LIFO exposing push, pop, top, depth, full, empty.
  - Fault decision stays in seq_control.

Test Plan:
- CALL 0x100 at PC 0x010, then RET -> PC = 0x100, depth = 1; then PC = 0x012, depth = 0.
- STACK_DEPTH=4: five nested CALLs -> the fifth sets fault = 1, fault_code = 01, PC frozen at the fifth CALL. fault_clr -> PC = 0, depth = 0.
- LOOP imm=3 at 0x020, body 0x022, ENDL at 0x024 -> body executes 3 times, then PC = 0x026. imm=0 -> body executes once.
- UNL imm=0x40: diverge_consensus=1 -> PC = 0x040; diverge_consensus=0 -> PC+2.
- stall held high 5 cycles during a CALL -> no push, PC unchanged, advance = 0. Releasing stall performs exactly one push.
- rst_n asserted low mid-LOOP and while HALTED -> PC = 0, depth = 0, halted = 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the seq_control instruction sequencer:
// FSM states, fault codes, opcode encodings and instruction field slices.
package seq_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } seq_state_e;

   typedef enum logic [1:0] {
      FC_NONE      = 2'b00,
      FC_OVERFLOW  = 2'b01,
      FC_UNDERFLOW = 2'b10,
      FC_NO_LOOP   = 2'b11
   } fault_code_e;

   // Opcode 0 and every unlisted encoding behave as a plain step.
   localparam logic [3:0] OP_JUMP = 4'h1;
   localparam logic [3:0] OP_UNL  = 4'h2;
   localparam logic [3:0] OP_CALL = 4'h3;
   localparam logic [3:0] OP_RET  = 4'h4;
   localparam logic [3:0] OP_LOOP = 4'h5;
   localparam logic [3:0] OP_ENDL = 4'h6;
   localparam logic [3:0] OP_HALT = 4'h7;

   localparam int OPCODE_MSB = 15;
   localparam int OPCODE_LSB = 12;
   localparam int ADDR_MSB   = 11;
   localparam int ADDR_LSB   = 0;
   localparam int IMM_MSB    = 7;
   localparam int IMM_LSB    = 0;

endpackage

// File: rtl/seq_call_stack.sv
// Parametrised LIFO holding return addresses; only the depth is reset,
// entry storage keeps its contents across reset.
module seq_call_stack #(
   parameter  int DEPTH   = 16,
   parameter  int WIDTH   = 12,
   localparam int DEPTH_W = $clog2(DEPTH + 1),
   localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic               clear_i,
   input  logic [WIDTH-1:0]   data_i,
   output logic [WIDTH-1:0]   top_o,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               full_o,
   output logic               empty_o
);

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [DEPTH_W-1:0] depth_q;
   logic [DEPTH_W-1:0] depth_d;
   logic [DEPTH_W-1:0] top_idx;
   logic               do_push;
   logic               do_pop;

   assign full_o  = (depth_q == DEPTH_W'(DEPTH));
   assign empty_o = (depth_q == '0);
   assign depth_o = depth_q;
   assign do_push = push_i && !full_o && !clear_i;
   assign do_pop  = pop_i && !empty_o && !clear_i;
   assign top_idx = depth_q - DEPTH_W'(1);
   assign top_o   = mem_q[top_idx[ADDR_W-1:0]];

   always_comb begin
      depth_d = depth_q;
      if (clear_i) begin
         depth_d = '0;
      end else if (do_push) begin
         depth_d = depth_q + DEPTH_W'(1);
      end else if (do_pop) begin
         depth_d = depth_q - DEPTH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[depth_q[ADDR_W-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/seq_control.sv
// Instruction sequencer: fetch PC, call stack, single-level hardware loop, HALT/FAULT.
// Define SEQ_PERF_CNT_EN to add saturating retired_count / stall_count outputs.
module seq_control
   import seq_pkg::*;
#(
   parameter  int PC_WIDTH       = 12,
   parameter  int STACK_DEPTH    = 16,
   parameter  int INSTR_WIDTH    = 16,
   parameter  int LOOP_CNT_WIDTH = 8,
   localparam int DEPTH_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INSTR_WIDTH-1:0] instruction,
   input  logic                   instr_valid,
   input  logic                   stall,
   input  logic                   diverge_consensus,
   input  logic                   resume,
   input  logic                   fault_clr,
   output logic [PC_WIDTH-1:0]    program_counter,
   output logic [PC_WIDTH-1:0]    next_program_counter,
   output logic [DEPTH_W-1:0]     stack_depth,
   output logic                   advance,
   output logic                   halted,
   output logic                   fault,
   output logic [1:0]             fault_code
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]            retired_count,
   output logic [31:0]            stall_count
`endif
);

   localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INSTR_WIDTH / 8);

   seq_state_e                state_q, state_d;
   fault_code_e               fc_q, fc_d;
   logic [PC_WIDTH-1:0]       pc_q, pc_d;
   logic                      loop_active_q, loop_active_d;
   logic [LOOP_CNT_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
   logic [PC_WIDTH-1:0]       loop_start_q, loop_start_d;

   logic [3:0]                opcode;
   logic [PC_WIDTH-1:0]       addr_ext;
   logic [PC_WIDTH-1:0]       imm_ext;
   logic [LOOP_CNT_WIDTH-1:0] imm_cnt;
   logic [PC_WIDTH-1:0]       pc_step;
   logic                      push, pop, clear;
   logic [PC_WIDTH-1:0]       stack_top;
   logic                      stack_full, stack_empty;

   assign opcode   = instruction[OPCODE_MSB:OPCODE_LSB];
   assign addr_ext = PC_WIDTH'(instruction[ADDR_MSB:ADDR_LSB]);
   assign imm_ext  = PC_WIDTH'(instruction[IMM_MSB:IMM_LSB]);
   assign imm_cnt  = LOOP_CNT_WIDTH'(instruction[IMM_MSB:IMM_LSB]);
   assign pc_step  = pc_q + STEP;
   assign advance  = (state_q == ST_RUN) && instr_valid && !stall;

   seq_call_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (PC_WIDTH)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .clear_i (clear),
      .data_i  (pc_step),
      .top_o   (stack_top),
      .depth_o (stack_depth),
      .full_o  (stack_full),
      .empty_o (stack_empty)
   );

   always_comb begin
      state_d       = state_q;
      fc_d          = fc_q;
      pc_d          = pc_q;
      loop_active_d = loop_active_q;
      loop_cnt_d    = loop_cnt_q;
      loop_start_d  = loop_start_q;
      push          = 1'b0;
      pop           = 1'b0;
      clear         = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (advance) begin
               case (opcode)
                  OP_JUMP: pc_d = addr_ext;
                  OP_UNL:  pc_d = diverge_consensus ? imm_ext : pc_step;
                  OP_CALL: begin
                     if (stack_full) begin
                        state_d = ST_FAULT;
                        fc_d    = FC_OVERFLOW;
                     end else begin
                        push = 1'b1;
                        pc_d = addr_ext;
                     end
                  end
                  OP_RET: begin
                     if (stack_empty) begin
                        state_d = ST_FAULT;
                        fc_d    = FC_UNDERFLOW;
                     end else begin
                        pop  = 1'b1;
                        pc_d = stack_top;
                     end
                  end
                  OP_LOOP: begin
                     loop_active_d = 1'b1;
                     loop_start_d  = pc_step;
                     loop_cnt_d    = (imm_cnt == '0) ? LOOP_CNT_WIDTH'(1) : imm_cnt;
                     pc_d          = pc_step;
                  end
                  OP_ENDL: begin
                     if (!loop_active_q) begin
                        state_d = ST_FAULT;
                        fc_d    = FC_NO_LOOP;
                     end else if (loop_cnt_q > LOOP_CNT_WIDTH'(1)) begin
                        loop_cnt_d = loop_cnt_q - LOOP_CNT_WIDTH'(1);
                        pc_d       = loop_start_q;
                     end else begin
                        loop_active_d = 1'b0;
                        pc_d          = pc_step;
                     end
                  end
                  OP_HALT: begin
                     state_d = ST_HALTED;
                     pc_d    = pc_step;
                  end
                  default: pc_d = pc_step;
               endcase
            end
         end
         ST_HALTED: begin
            if (resume) state_d = ST_RUN;
         end
         ST_FAULT: begin
            // Recovery restarts the program from address 0 with a clean context.
            if (fault_clr) begin
               state_d       = ST_RUN;
               fc_d          = FC_NONE;
               pc_d          = '0;
               clear         = 1'b1;
               loop_active_d = 1'b0;
               loop_cnt_d    = '0;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         fc_q          <= FC_NONE;
         pc_q          <= '0;
         loop_active_q <= 1'b0;
         loop_cnt_q    <= '0;
         loop_start_q  <= '0;
      end else begin
         state_q       <= state_d;
         fc_q          <= fc_d;
         pc_q          <= pc_d;
         loop_active_q <= loop_active_d;
         loop_cnt_q    <= loop_cnt_d;
         loop_start_q  <= loop_start_d;
      end
   end

   assign program_counter      = pc_q;
   assign next_program_counter = pc_d;
   assign halted               = (state_q == ST_HALTED);
   assign fault                = (state_q == ST_FAULT);
   assign fault_code           = fc_q;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] retired_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         if (advance && (retired_q != '1)) retired_q <= retired_q + 32'd1;
         if ((state_q == ST_RUN) && instr_valid && stall && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign retired_count = retired_q;
   assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_seq_control.sv
// Self-checking bench for seq_control: directed program scenarios plus random
// stimulus, all outputs compared every cycle against a queue-based model.
module tb_seq_control;
   import seq_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [15:0] instruction;
   logic        instr_valid;
   logic        stall;
   logic        diverge_consensus;
   logic        resume;
   logic        fault_clr;
   logic [11:0] program_counter;
   logic [11:0] next_program_counter;
   logic [2:0]  stack_depth;
   logic        advance;
   logic        halted;
   logic        fault;
   logic [1:0]  fault_code;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] retired_count;
   logic [31:0] stall_count;
`endif

   seq_control #(
      .PC_WIDTH       (12),
      .STACK_DEPTH    (4),
      .INSTR_WIDTH    (16),
      .LOOP_CNT_WIDTH (8)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .instruction          (instruction),
      .instr_valid          (instr_valid),
      .stall                (stall),
      .diverge_consensus    (diverge_consensus),
      .resume               (resume),
      .fault_clr            (fault_clr),
      .program_counter      (program_counter),
      .next_program_counter (next_program_counter),
      .stack_depth          (stack_depth),
      .advance              (advance),
      .halted               (halted),
      .fault                (fault),
      .fault_code           (fault_code)
`ifdef SEQ_PERF_CNT_EN
      ,
      .retired_count        (retired_count),
      .stall_count          (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: state 0=RUN 1=HALTED 2=FAULT; stack kept as a queue of return addresses.
   int          m_pc, m_state, m_fc, m_la, m_cnt, m_start;
   int          m_stack[$];
   logic [31:0] m_ret, m_stl;
   logic [15:0] prog [0:2047];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [11:0] a);
      return {op, a};
   endfunction

   task automatic model_reset();
      m_pc = 0; m_state = 0; m_fc = 0; m_la = 0; m_cnt = 0; m_start = 0;
      m_stack.delete();
      m_ret = '0; m_stl = '0;
   endtask

   // One clock: drive inputs after negedge, check all outputs, advance model at posedge.
   task automatic step(input logic [15:0] ins, input bit v, input bit st, input bit dc,
                       input bit rs, input bit fc);
      int n_pc, n_state, n_fc, n_la, n_cnt, n_start, push_val, imm;
      bit adv, do_push, do_pop, do_clr;
      instruction = ins; instr_valid = v; stall = st;
      diverge_consensus = dc; resume = rs; fault_clr = fc;
      imm = int'(ins[7:0]);
      n_pc = m_pc; n_state = m_state; n_fc = m_fc; n_la = m_la; n_cnt = m_cnt; n_start = m_start;
      push_val = 0; do_push = 0; do_pop = 0; do_clr = 0;
      adv = (m_state == 0) && v && !st;
      if (adv) begin
         case (ins[15:12])
            OP_JUMP: n_pc = int'(ins[11:0]);
            OP_UNL:  n_pc = dc ? imm : (m_pc + 2) % 4096;
            OP_CALL: begin
               if (m_stack.size() < 4) begin
                  do_push = 1; push_val = (m_pc + 2) % 4096; n_pc = int'(ins[11:0]);
               end else begin
                  n_state = 2; n_fc = 1;
               end
            end
            OP_RET: begin
               if (m_stack.size() > 0) begin
                  do_pop = 1; n_pc = m_stack[m_stack.size()-1];
               end else begin
                  n_state = 2; n_fc = 2;
               end
            end
            OP_LOOP: begin
               n_la = 1; n_start = (m_pc + 2) % 4096; n_cnt = (imm == 0) ? 1 : imm;
               n_pc = (m_pc + 2) % 4096;
            end
            OP_ENDL: begin
               if (!m_la) begin
                  n_state = 2; n_fc = 3;
               end else if (m_cnt > 1) begin
                  n_cnt = m_cnt - 1; n_pc = m_start;
               end else begin
                  n_la = 0; n_pc = (m_pc + 2) % 4096;
               end
            end
            OP_HALT: begin
               n_state = 1; n_pc = (m_pc + 2) % 4096;
            end
            default: n_pc = (m_pc + 2) % 4096;
         endcase
      end else if (m_state == 1) begin
         if (rs) n_state = 0;
      end else if (m_state == 2) begin
         if (fc) begin
            n_state = 0; n_pc = 0; do_clr = 1; n_la = 0; n_cnt = 0; n_fc = 0;
         end
      end
      #1;
      chk("advance", 32'(advance), 32'(adv));
      chk("pc", 32'(program_counter), 32'(m_pc));
      if (!(m_state == 2 && fc)) chk("next_pc", 32'(next_program_counter), 32'(n_pc));
      chk("depth", 32'(stack_depth), 32'(m_stack.size()));
      chk("halted", 32'(halted), 32'(m_state == 1));
      chk("fault", 32'(fault), 32'(m_state == 2));
      chk("fault_code", 32'(fault_code), 32'(m_fc));
`ifdef SEQ_PERF_CNT_EN
      chk("retired_count", retired_count, m_ret);
      chk("stall_count", stall_count, m_stl);
`endif
      @(posedge clk);
      if (m_state == 0 && adv && m_ret != 32'hFFFF_FFFF) m_ret++;
      if (m_state == 0 && v && st && m_stl != 32'hFFFF_FFFF) m_stl++;
      if (do_clr) m_stack.delete();
      if (do_push) m_stack.push_back(push_val);
      if (do_pop) void'(m_stack.pop_back());
      m_pc = n_pc; m_state = n_state; m_fc = n_fc; m_la = n_la; m_cnt = n_cnt; m_start = n_start;
      @(negedge clk);
   endtask

   task automatic async_reset(input string tag);
      instr_valid = 0; stall = 0; resume = 0; fault_clr = 0;
      rst_n = 1'b0;
      #1;
      chk({tag, "_pc"}, 32'(program_counter), 32'h0);
      chk({tag, "_depth"}, 32'(stack_depth), 32'h0);
      chk({tag, "_halted"}, 32'(halted), 32'h0);
      chk({tag, "_fault"}, 32'(fault), 32'h0);
      model_reset();
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Runs the program memory from the current PC until the model reaches stop_pc.
   task automatic run_prog(input int stop_pc, output int body);
      body = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_pc == stop_pc) break;
         if (program_counter == 12'h022) body++;
         step(prog[m_pc[11:1]], 1, 0, 0, 0, 0);
      end
   endtask

   initial begin
      int body;
      for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
      instruction = '0; instr_valid = 0; stall = 0; diverge_consensus = 0;
      resume = 0; fault_clr = 0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_pc", 32'(program_counter), 32'h0);
      chk("reset_fault_code", 32'(fault_code), 32'h0);
      rst_n = 1'b1;

      // CALL / RET round trip
      step(mk(OP_JUMP, 12'h010), 1, 0, 0, 0, 0);
      chk("jump_pc", 32'(program_counter), 32'h010);
      step(mk(OP_CALL, 12'h100), 1, 0, 0, 0, 0);
      chk("call_pc", 32'(program_counter), 32'h100);
      chk("call_depth", 32'(stack_depth), 32'd1);
      step(mk(OP_RET, 12'h000), 1, 0, 0, 0, 0);
      chk("ret_pc", 32'(program_counter), 32'h012);
      chk("ret_depth", 32'(stack_depth), 32'd0);

      // UNL both ways
      step(mk(OP_UNL, 12'h040), 1, 0, 1, 0, 0);
      chk("unl_taken", 32'(program_counter), 32'h040);
      step(mk(OP_UNL, 12'h040), 1, 0, 0, 0, 0);
      chk("unl_not_taken", 32'(program_counter), 32'h042);

      // Stall held during a CALL
      for (int i = 0; i < 5; i++) step(mk(OP_CALL, 12'h200), 1, 1, 0, 0, 0);
      chk("stall_pc", 32'(program_counter), 32'h042);
      chk("stall_depth", 32'(stack_depth), 32'd0);
      step(mk(OP_CALL, 12'h200), 1, 0, 0, 0, 0);
      chk("unstall_pc", 32'(program_counter), 32'h200);
      chk("unstall_depth", 32'(stack_depth), 32'd1);
      step(mk(OP_RET, 12'h000), 1, 0, 0, 0, 0);

      // Overflow on the fifth nested CALL, resume ignored, fault_clr recovers
      for (int i = 0; i < 5; i++) step(mk(OP_CALL, 12'h300), 1, 0, 0, 0, 0);
      chk("ovf_fault", 32'(fault), 32'd1);
      chk("ovf_code", 32'(fault_code), 32'd1);
      chk("ovf_pc", 32'(program_counter), 32'h300);
      chk("ovf_depth", 32'(stack_depth), 32'd4);
      step(mk(OP_JUMP, 12'h123), 1, 0, 0, 1, 0);
      chk("ovf_resume_ignored", 32'(fault), 32'd1);
      step(16'h0000, 0, 0, 0, 0, 1);
      chk("clr_pc", 32'(program_counter), 32'h000);
      chk("clr_depth", 32'(stack_depth), 32'd0);
      chk("clr_fault", 32'(fault), 32'd0);

      // Underflow
      step(mk(OP_RET, 12'h000), 1, 0, 0, 0, 0);
      chk("udf_code", 32'(fault_code), 32'd2);
      step(16'h0000, 0, 0, 0, 0, 1);

      // Hardware loop imm=3, then imm=0
      prog[12'h020 >> 1] = mk(OP_LOOP, 12'h003);
      prog[12'h024 >> 1] = mk(OP_ENDL, 12'h000);
      step(mk(OP_JUMP, 12'h020), 1, 0, 0, 0, 0);
      run_prog(12'h026, body);
      chk("loop3_body", 32'(body), 32'd3);
      chk("loop3_exit_pc", 32'(program_counter), 32'h026);
      prog[12'h020 >> 1] = mk(OP_LOOP, 12'h000);
      step(mk(OP_JUMP, 12'h020), 1, 0, 0, 0, 0);
      run_prog(12'h026, body);
      chk("loop0_body", 32'(body), 32'd1);
      chk("loop0_exit_pc", 32'(program_counter), 32'h026);

      // HALT then resume, then ENDL with no active loop
      step(mk(OP_HALT, 12'h000), 1, 0, 0, 0, 0);
      chk("halt_pc", 32'(program_counter), 32'h028);
      chk("halt_flag", 32'(halted), 32'd1);
      step(mk(OP_JUMP, 12'h300), 1, 1, 0, 0, 0);
      step(16'h0000, 0, 0, 0, 1, 0);
      chk("resume_halted", 32'(halted), 32'd0);
      step(mk(OP_ENDL, 12'h000), 1, 0, 0, 0, 0);
      chk("endl_code", 32'(fault_code), 32'd3);
      chk("endl_pc", 32'(program_counter), 32'h028);
      step(16'h0000, 0, 0, 0, 0, 1);

      // Asynchronous reset mid-loop and while halted
      prog[12'h020 >> 1] = mk(OP_LOOP, 12'h003);
      step(mk(OP_CALL, 12'h020), 1, 0, 0, 0, 0);
      step(prog[12'h020 >> 1], 1, 0, 0, 0, 0);
      async_reset("rst_loop");
      step(mk(OP_JUMP, 12'h030), 1, 0, 0, 0, 0);
      step(mk(OP_HALT, 12'h000), 1, 0, 0, 0, 0);
      async_reset("rst_halt");

      // Random stimulus
      for (int i = 0; i < 3000; i++) begin
         logic [3:0]  op;
         logic [11:0] a;
         op = 4'($urandom_range(0, 9));
         a  = 12'($urandom_range(0, 4095));
         if (op == OP_LOOP) a[7:0] = 8'($urandom_range(0, 3));
         step({op, a}, ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 4) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
